// File: rtl/dsp_out_pipelined_pkg.sv
// Shared constants for the pipelined DSP output block: default width,
// buffer depth and operation mode encodings.
package dsp_out_pipelined_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 4;
    localparam int unsigned DEPTH_DEF      = 2;

    typedef enum logic {
        MODE_MUL = 1'b0,
        MODE_ADD = 1'b1
    } mode_e;

endpackage

// File: rtl/dsp_out_pipelined_comb.sv
// Combinational multiply/add datapath: result is DATA_WIDTH bits wide and
// operands are half that width, so neither operation can overflow.
module dsp_combinational
    import dsp_out_pipelined_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic [DATA_WIDTH/2-1:0] a,
    input  logic [DATA_WIDTH/2-1:0] b,
    input  logic                    m,
    output logic [DATA_WIDTH-1:0]   result
);

    localparam int unsigned HW = DATA_WIDTH / 2;
    localparam int unsigned EW = DATA_WIDTH - HW;

    logic [DATA_WIDTH-1:0] a_ext_s;
    logic [DATA_WIDTH-1:0] b_ext_s;

    assign a_ext_s = {{EW{1'b0}}, a};
    assign b_ext_s = {{EW{1'b0}}, b};

    // Mode-selected arithmetic on zero-extended operands.
    always_comb begin
        result = {DATA_WIDTH{1'b0}};
        case (mode_e'(m))
            MODE_MUL: result = a_ext_s * b_ext_s;
            MODE_ADD: result = a_ext_s + b_ext_s;
            default:  result = {DATA_WIDTH{1'b0}};
        endcase
    end

endmodule

// File: rtl/dsp_out_pipelined.sv
// DSP result path followed by a two-entry output buffer with valid/ready
// handshakes on both sides; results leave in acceptance order.
module dsp_out_pipelined
    import dsp_out_pipelined_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned DEPTH      = DEPTH_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH/2-1:0] a,
    input  logic [DATA_WIDTH/2-1:0] b,
    input  logic                    m,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [DATA_WIDTH-1:0]   out,
    output logic                    out_valid,
    input  logic                    out_ready
);

    logic [DATA_WIDTH-1:0] result_s;
    logic [DATA_WIDTH-1:0] mem_r [0:1];
    logic [1:0]            count_r;
    logic                  wr_ptr_r;
    logic                  rd_ptr_r;
    logic                  accept_s;
    logic                  pop_s;

    dsp_combinational #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_comb (
        .a      (a),
        .b      (b),
        .m      (m),
        .result (result_s)
    );

    // in_ready is gated by rst so it drops immediately, not just once count clears.
    assign in_ready  = !rst && (count_r < 2'd2);
    assign out_valid = (count_r != 2'd0);
    assign out       = out_valid ? mem_r[rd_ptr_r] : {DATA_WIDTH{1'b0}};
    assign accept_s  = in_valid && in_ready;
    assign pop_s     = out_valid && out_ready;

    // Buffer storage, pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_r[0] <= {DATA_WIDTH{1'b0}};
            mem_r[1] <= {DATA_WIDTH{1'b0}};
            count_r  <= 2'd0;
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
        end else begin
            if (accept_s) begin
                mem_r[wr_ptr_r] <= result_s;
                wr_ptr_r        <= ~wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            case ({accept_s, pop_s})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: tb/tb_dsp_out_pipelined.sv
// Directed and streaming checks for dsp_out_pipelined at the default width.
module tb_dsp_out_pipelined;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] a;
    logic [1:0] b;
    logic       m;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] out;
    logic       out_valid;
    logic       out_ready;

    int total = 0;
    int bad   = 0;

    dsp_out_pipelined dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .m         (m),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out       (out),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; a = 2'd3; b = 2'd3; m = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        #2;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
        total++; if (out !== 4'd0) begin bad++; $display("FAIL rst_out: got %0d expected 0", out); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready: got %b expected 0", in_ready); end
        step();
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_release_in_ready: got %b expected 1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_no_accept: got %b expected 0", out_valid); end
    endtask

    task automatic test_mul();
        a = 2'd3; b = 2'd3; m = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        total++; if (out !== 4'd9 || out_valid !== 1'b1) begin bad++; $display("FAIL mul_3x3: got out=%0d v=%b expected out=9 v=1", out, out_valid); end
        step();
        total++; if (out_valid !== 1'b0 || out !== 4'd0) begin bad++; $display("FAIL mul_drain: got out=%0d v=%b expected out=0 v=0", out, out_valid); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        a = 2'd2; b = 2'd3; m = 1'b1; in_valid = 1'b1;
        step();
        total++; if (out !== 4'd5 || in_ready !== 1'b1) begin bad++; $display("FAIL bp_first: got out=%0d rdy=%b expected out=5 rdy=1", out, in_ready); end
        a = 2'd3; b = 2'd2; m = 1'b0;
        step();
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_full: got in_ready=%b expected 0", in_ready); end
        a = 2'd1; b = 2'd1; m = 1'b1;
        step();
        in_valid = 1'b0;
        total++; if (out !== 4'd5 || in_ready !== 1'b0) begin bad++; $display("FAIL bp_hold: got out=%0d rdy=%b expected out=5 rdy=0", out, in_ready); end
        out_ready = 1'b1;
        step();
        total++; if (out !== 4'd6 || out_valid !== 1'b1) begin bad++; $display("FAIL bp_second: got out=%0d v=%b expected out=6 v=1", out, out_valid); end
        step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_empty: got v=%b expected 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        a = 2'd2; b = 2'd2; m = 1'b0; in_valid = 1'b1;
        step();
        total++; if (out !== 4'd4) begin bad++; $display("FAIL b2b_head: got out=%0d expected 4", out); end
        a = 2'd1; b = 2'd1; m = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        total++; if (out !== 4'd2 || out_valid !== 1'b1 || in_ready !== 1'b1) begin bad++; $display("FAIL b2b_swap: got out=%0d v=%b rdy=%b expected out=2 v=1 rdy=1", out, out_valid, in_ready); end
        step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_empty: got v=%b expected 0", out_valid); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        a = 2'd3; b = 2'd3; m = 1'b0; in_valid = 1'b1;
        step();
        a = 2'd1; b = 2'd2; m = 1'b1;
        step();
        in_valid = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0 || out !== 4'd0 || in_ready !== 1'b0) begin bad++; $display("FAIL mid_rst: got out=%0d v=%b rdy=%b expected all 0", out, out_valid, in_ready); end
        #1;
        rst = 1'b0;
        #1;
        total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL mid_release: got rdy=%b v=%b expected rdy=1 v=0", in_ready, out_valid); end
        out_ready = 1'b1;
        step();
        total++; if (out_valid !== 1'b0 || out !== 4'd0) begin bad++; $display("FAIL mid_stale: got out=%0d v=%b expected out=0 v=0", out, out_valid); end
    endtask

    task automatic test_idle();
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            total++; if (out_valid !== 1'b0 || out !== 4'd0) begin bad++; $display("FAIL idle_%0d: got out=%0d v=%b expected 0", i, out, out_valid); end
        end
    endtask

    task automatic test_stream();
        logic [3:0] q[$];
        int sent = 0;
        int recv = 0;
        int cyc  = 0;
        while (recv < 1000 && cyc < 20000) begin
            in_valid  = (sent < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
            a         = 2'($urandom_range(0, 3));
            b         = 2'($urandom_range(0, 3));
            m         = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            #1;
            chk("stream_in_ready", int'(in_ready), int'(q.size() < 2));
            chk("stream_out_valid", int'(out_valid), int'(q.size() != 0));
            if (q.size() == 0) begin
                chk("stream_out_zero", int'(out), 0);
            end else if (out_ready) begin
                chk("stream_data", int'(out), int'(q[0]));
                void'(q.pop_front());
                recv++;
            end
            if (in_valid && in_ready) begin
                q.push_back(m ? ({2'b00, a} + {2'b00, b}) : ({2'b00, a} * {2'b00, b}));
                sent++;
            end
            step();
            cyc++;
        end
        in_valid = 1'b0;
        chk("stream_count", recv, 1000);
    endtask

    initial begin
        test_reset();
        test_mul();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_idle();
        test_stream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dsp_out_pipelined.md
DSP_OUT_PIPELINED -- requirements
Module: DSP_OUT_PIPELINED

Interface
REQ-001 SHALL have parameter: DATA_WIDTH, default 4, output width; operand width is DATA_WIDTH/2.
REQ-002 SHALL have parameter: DEPTH, default 2, output buffer entries; only 2 is supported.
REQ-003 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port: a  input  DATA_WIDTH/2  operand A.
REQ-006 SHALL have port: b  input  DATA_WIDTH/2  operand B.
REQ-007 SHALL have port: m  input  1  mode; 0 = multiply, 1 = add.
REQ-008 SHALL have port: in_valid  input  1  a, b and m are valid this cycle.
REQ-009 SHALL have port: in_ready  output  1  block can accept an operation this cycle.
REQ-010 SHALL have port: out  output  DATA_WIDTH  result at the buffer head.
REQ-011 SHALL have port: out_valid  output  1  out holds a valid result.
REQ-012 SHALL have port: out_ready  input  1  consumer takes out this cycle.

Function
REQ-013 SHALL compute result = a*b when m=0 and a+b zero-extended when m=1, both DATA_WIDTH bits; no truncation occurs (max 9 and 6 at width 4).
REQ-014 SHALL treat the result path as combinational: inputs are unregistered, and the only registers are the output buffer.
REQ-015 SHALL accept an operation on any rising edge with in_valid=1 and in_ready=1; the computed result is written to the buffer tail on that edge.
REQ-016 SHALL pop the head on any rising edge with out_valid=1 and out_ready=1.
REQ-017 SHALL drive in_ready = 1 iff count < 2 and rst = 0; in_ready is combinational from count only and does not depend on out_ready.
REQ-018 SHALL have latency 1: when the buffer is empty, a result accepted at edge N appears with out_valid=1 in the cycle after edge N.
REQ-019 SHALL, on simultaneous accept and pop, leave count unchanged; at count=1 the new result becomes the head on that edge.
REQ-020 SHALL preserve order: results leave in acceptance order, with 1-bit read and write pointers wrapping 1->0.
REQ-021 SHALL hold out stable while out_valid=1 and out_ready=0; in_valid is ignored at count=2.
REQ-022 SHALL drive out = 0 whenever out_valid = 0.
REQ-023 SHALL ignore out_ready when the buffer is empty; count does not underflow.

Reset
REQ-024 SHALL, while rst=1, force count=0, both pointers=0, out_valid=0, out=0 and in_ready=0 without waiting for a clock edge.
REQ-025 SHALL discard buffered results on reset mid-operation and accept nothing on an edge where rst=1.
REQ-026 SHALL reset storage entries to 0.

Structure
REQ-027 SHALL place the DATA_WIDTH default, DEPTH, and the mode encodings MODE_MUL=0 and MODE_ADD=1 in a shared package.
REQ-028 SHALL instantiate the existing DSP_COMBINATIONAL block as its single sub-module to compute the result.
REQ-029 SHALL use behavioural registers with asynchronous reset for the buffer, not reset-less DFF primitives.

Verification
REQ-030 SHALL cover: after reset, a=3, b=3, m=0, in_valid=1 for one cycle with out_ready=1 -> next cycle out=9, out_valid=1, then out_valid=0.
REQ-031 SHALL cover: out_ready=0; send (2,3,m=1) then (3,2,m=0) -> in_ready=0 after the second accept; raising out_ready gives out=5 then 6.
REQ-032 SHALL cover: count=1, simultaneous push (1,1,m=1) and pop -> count stays 1 and out=2 next cycle.
REQ-033 SHALL cover: count=2, rst pulsed between clock edges -> out_valid, out and in_ready go to 0 immediately; after release, in_ready=1 and the old results never appear.
REQ-034 SHALL cover: out_ready=1 with no input for 5 cycles -> out_valid=0 and out=0 throughout.
REQ-035 SHALL cover: random valid/ready streaming of 1000 operations against a reference queue -> every result is correct and in order, with no loss or duplication.
